operand_fetch_ctrl: RTL and testbench

// - Initiator side of the 8x16 register-file port: drives read addresses, enable, write-enable, write address/data.
// - Register file samples all of these on negedge clk and returns data_A/data_B registered at that negedge.
// - Accepts decoded ops (src1, src2, dst) via valid/ready and fetches both operands.
// - Accepts ALU writebacks and commits them to the register file.
// - An 8-bit scoreboard stalls RAW/WAW hazards; sits between decode and ALU in the RISC datapath.

---
 rtl/operand_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_ctrl.sv
// rtl/operand_fetch_ctrl.sv - operand fetch controller with scoreboard; optional forwarding under RF_BYPASS_EN
module operand_fetch_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_src1,
    input  logic [AW-1:0] in_src2,
    input  logic [AW-1:0] in_dst,
    input  logic          in_wb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op_a,
    output logic [DW-1:0] out_op_b,
    output logic [AW-1:0] out_dst,
    output logic          out_wb,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic          rf_en,
    output logic          rf_regen,
    output logic [AW-1:0] rf_readreg1,
    output logic [AW-1:0] rf_readreg2,
    output logic [AW-1:0] rf_writereg,
    output logic [DW-1:0] rf_data_result,
    input  logic [DW-1:0] rf_data_A,
    input  logic [DW-1:0] rf_data_B,
    output logic          wb_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [AW-1:0]   src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic            wbf_q, wbf_d;
    logic [DW-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic            regen_q, regen_d;
    logic [AW-1:0]   writereg_q, writereg_d;
    logic [DW-1:0]   result_q, result_d;
    logic            wb_err_q, wb_err_d;

    logic [NREG-1:0] busy;
    logic            src1_busy, src2_busy, hazard, accept;

    always_comb begin
        // A register in its commit cycle is already free for readers and writers.
        busy = pending_q;
        if (regen_q) busy[writereg_q] = 1'b0;
        src1_busy = busy[in_src1];
        src2_busy = busy[in_src2];
`ifdef RF_BYPASS_EN
        if (wb_valid && wb_reg == in_src1) src1_busy = 1'b0;
        if (wb_valid && wb_reg == in_src2) src2_busy = 1'b0;
`endif
        hazard = src1_busy | src2_busy | (in_wb & busy[in_dst]);

        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = ~hazard;
            S_HOLD:  in_ready = out_ready & in_valid & ~hazard;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;

        state_d = state_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dst_d   = dst_q;
        wbf_d   = wbf_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_READ;
            S_READ: begin
                op_a_d  = rf_data_A;
                op_b_d  = rf_data_B;
`ifdef RF_BYPASS_EN
                // The register file returns the old value when it writes the same cycle.
                if (regen_q && writereg_q == src1_q) op_a_d = result_q;
                if (regen_q && writereg_q == src2_q) op_b_d = result_q;
`endif
                state_d = S_HOLD;
            end
            S_HOLD: if (accept) state_d = S_READ;
                    else if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            src1_d = in_src1;
            src2_d = in_src2;
            dst_d  = in_dst;
            wbf_d  = in_wb;
        end

        pending_d = pending_q;
        if (regen_q) pending_d[writereg_q] = 1'b0;
        if (accept && in_wb) pending_d[in_dst] = 1'b1;

        regen_d    = wb_valid;
        writereg_d = wb_valid ? wb_reg : writereg_q;
        result_d   = wb_valid ? wb_data : result_q;
        wb_err_d   = wb_err_q | (wb_valid & ~busy[wb_reg]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
            wbf_q      <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            regen_q    <= 1'b0;
            writereg_q <= '0;
            result_q   <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            dst_q      <= dst_d;
            wbf_q      <= wbf_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            regen_q    <= regen_d;
            writereg_q <= writereg_d;
            result_q   <= result_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign out_valid      = (state_q == S_HOLD);
    assign out_op_a       = op_a_q;
    assign out_op_b       = op_b_q;
    assign out_dst        = dst_q;
    assign out_wb         = wbf_q;
    assign rf_en          = (state_q == S_READ) | regen_q;
    assign rf_regen       = regen_q;
    assign rf_readreg1    = src1_q;
    assign rf_readreg2    = src2_q;
    assign rf_writereg    = writereg_q;
    assign rf_data_result = result_q;
    assign wb_err         = wb_err_q;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb/tb_operand_fetch_ctrl.sv - directed self-checking bench with a negedge register-file model
module tb_operand_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  in_src1 = '0, in_src2 = '0, in_dst = '0;
    logic        in_wb = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_op_a, out_op_b;
    logic [2:0]  out_dst;
    logic        out_wb;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        rf_en, rf_regen;
    logic [2:0]  rf_readreg1, rf_readreg2, rf_writereg;
    logic [15:0] rf_data_result;
    logic [15:0] rf_data_A = '0, rf_data_B = '0;
    logic        wb_err;
    logic        preload = 1'b1;
    logic [15:0] mem [8];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] held_a, held_b;

    operand_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_dst(out_dst), .out_wb(out_wb),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .rf_en(rf_en), .rf_regen(rf_regen),
        .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
        .rf_writereg(rf_writereg), .rf_data_result(rf_data_result),
        .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Register file: reads see the value before a same-negedge write.
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
            mem[3] <= 16'h1234;
            mem[5] <= 16'h00FF;
        end else if (rf_en) begin
            rf_data_A <= mem[rf_readreg1];
            rf_data_B <= mem[rf_readreg2];
            if (rf_regen) mem[rf_writereg] <= rf_data_result;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic raw_test(input logic [2:0] r, input logic [15:0] d, input bit on_b);
        in_valid = 1'b1; in_src1 = 3'd0; in_src2 = 3'd0; in_dst = r; in_wb = 1'b1;
        #1 chk("raw_producer_accept", in_ready, 1);
        tick;
        if (on_b) begin in_src1 = 3'd0; in_src2 = r; end
        else begin in_src1 = r; in_src2 = 3'd0; end
        in_dst = 3'd1; in_wb = 1'b0;
        tick;
        out_ready = 1'b1;
        #1 chk("raw_stall_in_hold", in_ready, 0);
        tick;
        out_ready = 1'b0;
        #1 chk("raw_stall_in_idle", in_ready, 0);
        chk("raw_idle_out_valid", out_valid, 0);
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
        #1;
`ifdef RF_BYPASS_EN
        chk("raw_bypass_accept", in_ready, 1);
        tick;
        wb_valid = 1'b0; in_valid = 1'b0;
`else
        chk("raw_wait_wb_cycle", in_ready, 0);
        tick;
        wb_valid = 1'b0;
        #1 chk("raw_commit_accept", in_ready, 1);
        tick;
        in_valid = 1'b0;
`endif
        tick;
        chk("raw_out_valid", out_valid, 1);
        chk("raw_operand", on_b ? out_op_b : out_op_a, d);
        chk("raw_no_err", wb_err, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_regen", rf_regen, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_op_a", out_op_a, 0);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;

        // Basic fetch of R3/R5
        tick;
        in_valid = 1'b1; in_src1 = 3'd3; in_src2 = 3'd5; in_dst = 3'd0; in_wb = 1'b0;
        #1 chk("a_accept", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("a_read_out_valid", out_valid, 0);
        chk("a_read_rf_en", rf_en, 1);
        chk("a_read_addr", {rf_readreg1, rf_readreg2}, {3'd3, 3'd5});
        tick;
        chk("a_out_valid", out_valid, 1);
        chk("a_op_a", out_op_a, 16'h1234);
        chk("a_op_b", out_op_b, 16'h00FF);
        held_a = out_op_a; held_b = out_op_b;

        // Stall in HOLD, then back-to-back HOLD->READ
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_stable", {out_op_a, out_op_b}, {held_a, held_b});
        end
        out_ready = 1'b1; in_valid = 1'b1; in_src1 = 3'd5; in_src2 = 3'd3; in_dst = 3'd1;
        #1 chk("b2b_accept", in_ready, 1);
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_direct_read", {out_valid, rf_en}, 2'b01);
        tick;
        chk("b2b_op", {out_op_a, out_op_b, out_dst}, {16'h00FF, 16'h1234, 3'd1});
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("b2b_to_idle", out_valid, 0);

        // RAW stalls released by writeback
        raw_test(3'd2, 16'hBEEF, 1'b0);
        raw_test(3'd4, 16'hA5A5, 1'b1);

        // Writeback to a non-pending register
        wb_valid = 1'b1; wb_reg = 3'd7; wb_data = 16'h7777;
        tick;
        wb_valid = 1'b0;
        chk("err_set", wb_err, 1);
        chk("err_commit_regen", {rf_regen, rf_writereg, rf_data_result}, {1'b1, 3'd7, 16'h7777});
        repeat (3) tick;
        chk("err_sticky", wb_err, 1);
        chk("err_r7_written", mem[7], 16'h7777);

        // WAW hazard, then reset during READ
        in_valid = 1'b1; in_src1 = 3'd1; in_src2 = 3'd1; in_dst = 3'd6; in_wb = 1'b1;
        #1 chk("waw_first_accept", in_ready, 1);
        tick;
        in_src1 = 3'd0; in_src2 = 3'd0;
        tick;
        out_ready = 1'b1;
        #1 chk("waw_blocked", in_ready, 0);
        tick;
        out_ready = 1'b0; in_dst = 3'd0; in_wb = 1'b0;
        #1 chk("next_accept", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("pre_rst_read", rf_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {out_valid, rf_en, rf_regen, wb_err, out_wb}, 5'b0);
        chk("mid_rst_ops", {out_op_a, out_op_b}, 32'h0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_src1 = 3'd6; in_src2 = 3'd6; in_dst = 3'd6; in_wb = 1'b1;
        #1 chk("post_rst_pending_clear", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("post_rst_read", rf_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
